// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide sequencer.
package muldiv_pkg;

   localparam int MD_XLEN  = 32;
   localparam int MD_CNT_W = 6;

   typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} md_state_t;
   typedef enum logic [1:0] {MULTU, MULT, DIVU, DIV} md_op_t;

   function automatic logic op_is_div(input md_op_t o);
      return (o == DIVU) || (o == DIV);
   endfunction

   function automatic logic op_is_signed(input md_op_t o);
      return (o == MULT) || (o == DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath.
//   Multiply: {acc,shreg} holds partial product / remaining multiplier bits;
//             add the multiplicand when the multiplier LSB is set, then shift right.
//   Divide:   {acc,shreg} holds partial remainder / remaining dividend bits;
//             shift left one bit, trial-subtract the divisor, keep on success and
//             shift a quotient bit of 1 (else 0) into the bottom of shreg.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] shreg_i,
   input  logic [XLEN-1:0] opnd_i,
   input  logic            is_div_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] shreg_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] diff;
   logic            fits;

   // Compute both iteration flavours and select on is_div_i.
   always_comb begin
      sum   = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : '0);
      trial = {acc_i, shreg_i[XLEN-1]};
      fits  = (trial >= {1'b0, opnd_i});
      diff  = trial[XLEN-1:0] - opnd_i;
      if (is_div_i) begin
         acc_o   = fits ? diff : trial[XLEN-1:0];
         shreg_o = {shreg_i[XLEN-2:0], fits};
      end else begin
         acc_o   = sum[XLEN:1];
         shreg_o = {sum[0], shreg_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU. Owns HI/LO.
// Sequence: IDLE -> PREP (sign handling) -> RUN (XLEN iterations) -> FIX (sign
// correction and HI/LO write) -> IDLE. done pulses for the cycle after the write.
//
// Handshake: start is a request that EX keeps asserted for as long as stall is
// high; it is accepted at the first rising edge where the unit is IDLE and flush
// is low. stall = busy & (start | rd_hilo), so an MFHI/MFLO or a new mul/div is
// held until the done cycle, in which it sees the fresh HI/LO unstalled.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN  = MD_XLEN,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   input  logic            rd_hilo,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic            div_by_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output md_state_t       dbg_state
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   md_state_t         state_q, state_d;
   md_op_t            op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   shreg_q, shreg_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              qsign_q, qsign_d;
   logic              rsign_q, rsign_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;

   logic              is_div;
   logic              is_signed;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   step_acc;
   logic [XLEN-1:0]   step_shreg;
   logic [2*XLEN-1:0] prod_res;
   logic [XLEN-1:0]   quot_res;
   logic [XLEN-1:0]   rem_res;
   logic              div_zero;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc_i    (acc_q),
      .shreg_i  (shreg_q),
      .opnd_i   (opnd_q),
      .is_div_i (is_div),
      .acc_o    (step_acc),
      .shreg_o  (step_shreg)
   );

   // Operand magnitudes and final sign-corrected results from the captured state.
   always_comb begin
      is_div    = op_is_div(op_q);
      is_signed = op_is_signed(op_q);
      mag_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
      mag_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
      prod_res  = qsign_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
      quot_res  = qsign_q ? -shreg_q : shreg_q;
      rem_res   = rsign_q ? -acc_q : acc_q;
      div_zero  = (b_q == '0);
   end

   // Next-state and datapath update; flush aborts any in-flight phase without a write.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      shreg_d = shreg_q;
      opnd_d  = opnd_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               state_d = PREP;
               op_d    = md_op_t'(op);
               a_d     = op_a;
               b_d     = op_b;
            end
         end
         PREP: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
               cnt_d   = '0;
               acc_d   = '0;
               shreg_d = is_div ? mag_a : mag_b;
               opnd_d  = is_div ? mag_b : mag_a;
               qsign_d = is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
               rsign_d = is_signed && a_q[XLEN-1];
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d   = step_acc;
               shreg_d = step_shreg;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (is_div) begin
                  dbz_d = div_zero;
                  hi_d  = div_zero ? a_q : rem_res;
                  lo_d  = div_zero ? '1 : quot_res;
               end else begin
                  hi_d  = prod_res[2*XLEN-1:XLEN];
                  lo_d  = prod_res[XLEN-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything including HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= MULTU;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         shreg_q <= '0;
         opnd_q  <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         shreg_q <= shreg_d;
         opnd_q  <= opnd_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   // Status outputs.
   always_comb begin
      busy        = (state_q != IDLE);
      stall       = busy && (rd_hilo || start);
      done        = done_q;
      div_by_zero = dbz_q;
      hi          = hi_q;
      lo          = lo_q;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, multi-cycle corner sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        flush = 1'b0;
   logic        rd_hilo = 1'b0;
   logic        busy, stall, done, div_by_zero;
   logic [31:0] hi, lo;
   md_state_t   dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [64:0] exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   vec_t vecs[10];

   muldiv_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .rd_hilo     (rd_hilo),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo),
      .dbg_state   (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: results straight from the arithmetic definition of each op.
   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz);
      longint sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rdbz = 1'b0;
      case (o)
         2'd0: begin
            up = {32'b0, a} * {32'b0, b};
            rhi = up[63:32]; rlo = up[31:0];
         end
         2'd1: begin
            sp = sa * sb;
            up = 64'(sp);
            rhi = up[63:32]; rlo = up[31:0];
         end
         2'd2: begin
            if (b == 0) begin rhi = a; rlo = 32'hFFFF_FFFF; rdbz = 1'b1; end
            else begin rlo = a / b; rhi = a % b; end
         end
         default: begin
            if (b == 0) begin rhi = a; rlo = 32'hFFFF_FFFF; rdbz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rlo = 32'h8000_0000; rhi = 32'h0; end
            else begin
               sq = sa / sb; sr = sa % sb;
               rlo = sq[31:0]; rhi = sr[31:0];
            end
         end
      endcase
   endfunction

   // Wait (bounded) until done; lat counts cycles after the start cycle.
   task automatic wait_done(output int lat, output int busy_cyc);
      lat = 0; busy_cyc = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         #1;
         if (busy) busy_cyc++;
      end while (!done && lat < 100);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc);
      @(negedge clk);
      start = 1'b1; op = o; op_a = a; op_b = b;
      wait_done(lat, busy_cyc);
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk); #1;
         if (done) pulses++;
      end
   endtask

   initial begin
      int lat, bc, bad, pulses;
      logic [31:0] rhi, rlo, ra, rb;
      logic rdbz;
      logic [1:0] ro;
      logic [64:0] e;

      vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
      vecs[1] = '{2'd1, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2] = '{2'd3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
      vecs[4] = '{2'd2, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{2'd3, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[6] = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[7] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
      vecs[8] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
      vecs[9] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0,         1'b0};

      // reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      check("rst_stall", stall, 0);

      // directed vector table
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'd35);
         check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd34);
         check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
         @(negedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), done, 0);
         check($sformatf("vec%0d_dbz_clear", i), div_by_zero, 0);
      end

      // rd_hilo held from cycle 3: stalled until the done cycle
      @(negedge clk);
      start = 1'b1; op = 2'd0; op_a = 32'd3; op_b = 32'd5;
      bad = 0;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         start = 1'b0;
         rd_hilo = (k >= 3);
         #1;
         if (stall !== (k >= 3)) bad++;
      end
      @(negedge clk); #1;
      check("rdhilo_stall_cycles", 64'(bad), 0);
      check("rdhilo_done", done, 1);
      check("rdhilo_stall_done", stall, 0);
      check("rdhilo_new_lo", lo, 32'd15);
      check("rdhilo_new_hi", hi, 32'd0);
      rd_hilo = 1'b0;

      // second start while busy: stalled, accepted in the done cycle
      @(negedge clk);
      start = 1'b1; op = 2'd2; op_a = 32'd100; op_b = 32'd7;
      bad = 0;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         start = (k >= 5);
         if (k == 5) begin op = 2'd0; op_a = 32'd6; op_b = 32'd7; end
         #1;
         if (stall !== (k >= 5)) bad++;
         if (!busy) bad++;
      end
      @(negedge clk); #1;
      check("start_busy_stall", 64'(bad), 0);
      check("start_busy_done", done, 1);
      check("start_busy_stall_done", stall, 0);
      check("start_busy_first_hi", hi, 32'd2);
      check("start_busy_first_lo", lo, 32'd14);
      wait_done(lat, bc);
      check("start_busy_second_busy", 64'(bc), 64'd34);
      check("start_busy_second_lat", 64'(lat), 64'd35);
      check("start_busy_second_lo", lo, 32'd42);
      check("start_busy_second_hi", hi, 32'd0);

      // known HI/LO before the abort sequences
      run_op(2'd0, 32'hFFFF_FFFF, 32'h2, lat, bc);
      check("setup_lo", lo, 32'hFFFF_FFFE);

      // flush in RUN iteration 10
      @(negedge clk);
      start = 1'b1; op = 2'd2; op_a = 32'd100; op_b = 32'd7;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (k == 12);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_run_busy", busy, 0);
      count_done(40, pulses);
      check("flush_run_no_done", 64'(pulses), 0);
      check("flush_run_hi", hi, 32'h1);
      check("flush_run_lo", lo, 32'hFFFF_FFFE);

      // flush coinciding with the FIX write edge
      @(negedge clk);
      start = 1'b1; op = 2'd0; op_a = 32'd9; op_b = 32'd9;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (k == 34);
      end
      count_done(40, pulses);
      flush = 1'b0;
      check("flush_fix_no_done", 64'(pulses), 0);
      check("flush_fix_hi", hi, 32'h1);
      check("flush_fix_lo", lo, 32'hFFFF_FFFE);

      // reset in RUN
      @(negedge clk);
      start = 1'b1; op = 2'd1; op_a = 32'd11; op_b = 32'd13;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start = 1'b0;
         rst = (k == 12);
      end
      @(negedge clk);
      rst = 1'b0;
      rd_hilo = 1'b1;
      #1;
      check("rst_run_busy", busy, 0);
      check("rst_run_stall", stall, 0);
      check("rst_run_done", done, 0);
      check("rst_run_hi", hi, 0);
      check("rst_run_lo", lo, 0);
      rd_hilo = 1'b0;

      // flush together with start in IDLE
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'd0; op_a = 32'd3; op_b = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_start_busy", busy, 0);
      count_done(40, pulses);
      check("flush_start_no_done", 64'(pulses), 0);
      check("flush_start_lo", lo, 0);

      // random operations against the reference model
      for (int n = 0; n < 40; n++) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: ra = 32'h0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            3: ra = 32'h1;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: rb = 32'h8000_0000;
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'h1;
            default: rb = $urandom;
         endcase
         ref_model(ro, ra, rb, rhi, rlo, rdbz);
         exp_q.push_back({rdbz, rhi, rlo});
         run_op(ro, ra, rb, lat, bc);
         e = exp_q.pop_front();
         check($sformatf("rnd%0d_lat op=%0d a=%h b=%h", n, ro, ra, rb), 64'(lat), 64'd35);
         check($sformatf("rnd%0d_hilo op=%0d a=%h b=%h", n, ro, ra, rb), {hi, lo}, e[63:0]);
         check($sformatf("rnd%0d_dbz op=%0d a=%h b=%h", n, ro, ra, rb), div_by_zero, e[64]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
